gray_step_arbiter: RTL and testbench
====================================

# gray_step_arbiter

Controller that shares one Gray-code counter between several debounced button requesters. It converts each requester's rising edge into a queued step request and grants the queued requests one at a time in round-robin order. For each grant it issues a single-cycle step pulse, with a per-requester direction, to the counter. It sits between the debouncer bank and the Gray counter inside the counter system and enforces a minimum spacing between steps so the LED value is visible.

## Interface
- REQS, 4, number of requesters (2..8)
- GAP, 3, idle cycles enforced after every step pulse (>=1)
- DIR_MASK, 4'b0000, REQS bits; bit i=1 → requester i steps down, 0 → up
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge
- en  in  1  grant enable; 0 holds off new grants, collection continues
- req  in  REQS  debounced button levels, one per requester
- step  out  1  one-cycle pulse: advance Gray counter by one
- dir  out  1  direction qualifying step (1=down); 0 when step=0
- grant  out  REQS  one-hot requester served, valid only while step=1, else 0
- pending  out  REQS  queued-request flags
- dropped  out  REQS  one-cycle pulse: edge lost because request already queued
- busy  out  1  state != IDLE

## Operation
- Edge detect: req_q <= req each cycle; rise[i] = req[i] & ~req_q[i].
- Queue: pending[i] <= 1 on rise[i]. The bit clears when requester i is granted.
- Simultaneous grant-clear and rise[i] on the same edge: pending[i] stays 1. The new edge is kept, not dropped.
- rise[i] while pending[i]=1 and i is not being granted: pending is unchanged and dropped[i]=1 for the next cycle.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when en=1 and pending!=0. The winner is the first set pending bit searching ptr, ptr+1, … mod REQS.
  - On that edge: step<=1, grant<=onehot(winner), dir<=DIR_MASK[winner], pending[winner] cleared, ptr<=(winner+1) mod REQS.
  - ISSUE → WAIT unconditionally. step, grant and dir return to 0. gap_cnt loads GAP-1.
  - WAIT decrements gap_cnt and goes to IDLE when gap_cnt=0. en is ignored in WAIT.
- Arbitration is evaluated only in IDLE. Requests arriving in ISSUE/WAIT queue normally.
- gap_cnt width is clog2(GAP)+1. ptr width is clog2(REQS).

## Timing
- Reset (rst=0 at edge):
  - state=IDLE, ptr=0, pending=0, gap_cnt=0.
  - step=0, dir=0, grant=0, dropped=0, busy=0.
  - req_q loads all-ones, so a button held through reset release produces no step.
- Reset mid-operation: everything above applies at the same edge. Queued requests are discarded and an in-flight step pulse is cut off.
- Latency: req[i] first sampled 1 at edge t sets pending[i] at t. With IDLE and en=1, step=1 in the cycle after edge t+1.
- Back-to-back service: with requests continuously pending, step pulses are exactly GAP+2 cycles apart (ISSUE 1 + WAIT GAP + IDLE 1).
- busy=1 from the ISSUE edge through the last WAIT cycle.
- en falling in WAIT has no effect until IDLE. en rising in IDLE with pending!=0 grants on the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset release with req=4'b0010 held → no step and pending=0 over 20 cycles. Releasing and then re-pressing req[1] gives one step with grant=4'b0010 two edges after the press.
- REQS=4, GAP=3, DIR_MASK=4'b0100; req rises 4'b1111 on one edge → four steps, grants 0001,0010,0100,1000, dir 0,0,1,0, pulses 5 cycles apart, ptr ends at 0.
- req[0] pulses 3 times within 5 cycles while ungranted → pending[0]=1 and dropped[0] pulses twice. Only one step results.
- Served requester re-presses on its grant edge → pending stays 1 and it is served again after the others. Check fairness: with req[0] and req[2] continuously re-pressed, grants alternate 0001/0100.
- en=0 with req rising 4'b0011 → no step and pending=4'b0011. Raising en → grant 0001, then 0010, GAP+2 cycles apart.
- Assert rst=0 during WAIT with pending=4'b1000 → all outputs and pending are 0 at the next edge, and no step follows reset release.

Source files
------------

// File: rtl/gray_step_arbiter_if.sv
// Handshake bundle between the debouncer bank, the step arbiter and its observers.
interface gray_step_arbiter_if #(
    parameter int unsigned REQS = 4
);
    logic            en;
    logic [REQS-1:0] req;
    logic            step;
    logic            dir;
    logic [REQS-1:0] grant;
    logic [REQS-1:0] pending;
    logic [REQS-1:0] dropped;
    logic            busy;

    modport master (
        output en, req,
        input  step, dir, grant, pending, dropped, busy
    );

    modport slave (
        input  en, req,
        output step, dir, grant, pending, dropped, busy
    );
endinterface

// File: rtl/gray_step_arbiter.sv
// Queues rising edges from debounced buttons and grants them round-robin as
// spaced single-cycle step pulses for a shared Gray-code counter.
module gray_step_arbiter #(
    parameter int unsigned     REQS     = 4,
    parameter int unsigned     GAP      = 3,
    parameter logic [REQS-1:0] DIR_MASK = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_step_arbiter_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(REQS);
    localparam int unsigned GAP_W = $clog2(GAP) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]       state,   state_nxt;
    logic [PTR_W-1:0] ptr,     ptr_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [REQS-1:0]  pending, pending_nxt;
    logic [REQS-1:0]  req_q;
    logic [REQS-1:0]  dropped, dropped_nxt;
    logic [REQS-1:0]  grant,   grant_nxt;
    logic             step,    step_nxt;
    logic             dir,     dir_nxt;
    logic             busy,    busy_nxt;

    logic [REQS-1:0]  rise;
    logic [REQS-1:0]  clr;
    logic [PTR_W:0]   pick;
    logic             win_valid;
    logic [PTR_W-1:0] win;

    // First set bit scanning start, start+1, ... mod REQS; MSB flags a hit.
    function automatic logic [PTR_W:0] pick_winner(input logic [REQS-1:0]  p,
                                                   input logic [PTR_W-1:0] start);
        logic [PTR_W:0] r;
        int unsigned    idx;
        r = '0;
        for (int k = int'(REQS) - 1; k >= 0; k--) begin
            idx = (32'(start) + 32'(k)) % REQS;
            if (p[PTR_W'(idx)]) r = {1'b1, PTR_W'(idx)};
        end
        return r;
    endfunction

    assign rise      = bus.req & ~req_q;
    assign pick      = pick_winner(pending, ptr);
    assign win_valid = pick[PTR_W];
    assign win       = pick[PTR_W-1:0];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gap_nxt   = gap_cnt;
        step_nxt  = 1'b0;
        dir_nxt   = 1'b0;
        grant_nxt = '0;
        clr       = '0;
        case (state)
            IDLE: begin
                if (bus.en && win_valid) begin
                    state_nxt = ISSUE;
                    step_nxt  = 1'b1;
                    grant_nxt = REQS'(1) << win;
                    dir_nxt   = DIR_MASK[win];
                    clr       = REQS'(1) << win;
                    ptr_nxt   = PTR_W'((32'(win) + 32'd1) % REQS);
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                gap_nxt   = GAP_W'(GAP - 1);
            end
            WAIT: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_nxt   = gap_cnt - GAP_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
        // A rise on the grant edge re-queues the requester instead of being lost.
        pending_nxt = (pending & ~clr) | rise;
        dropped_nxt = rise & pending & ~clr;
        busy_nxt    = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gap_cnt <= '0;
            pending <= '0;
            req_q   <= '1;
            dropped <= '0;
            grant   <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gap_cnt <= gap_nxt;
            pending <= pending_nxt;
            req_q   <= bus.req;
            dropped <= dropped_nxt;
            grant   <= grant_nxt;
            step    <= step_nxt;
            dir     <= dir_nxt;
            busy    <= busy_nxt;
        end
    end

    assign bus.step    = step;
    assign bus.dir     = dir;
    assign bus.grant   = grant;
    assign bus.pending = pending;
    assign bus.dropped = dropped;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: cooldown-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_gray_step_arbiter;
    localparam int unsigned REQS = 4;
    localparam int unsigned GAP  = 3;
    localparam logic [3:0]  DMSK = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gray_step_arbiter_if #(.REQS(REQS)) bus ();

    gray_step_arbiter #(.REQS(REQS), .GAP(GAP), .DIR_MASK(DMSK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle time %0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a cooldown counter of cycles before the next grant is allowed.
    logic [3:0] m_pending, m_prev, m_grant, m_dropped;
    logic       m_step, m_dir, m_busy;
    int         m_ptr, m_hold;

    always @(posedge clk) begin
        logic [3:0] rise, clr;
        int idx;
        if (!rst) begin
            m_pending = '0; m_prev = '1; m_grant = '0; m_dropped = '0;
            m_step = 0; m_dir = 0; m_busy = 0; m_ptr = 0; m_hold = 0;
        end else begin
            rise = bus.req & ~m_prev;
            m_prev = bus.req;
            m_step = 0; m_grant = '0; m_dir = 0; clr = '0;
            if (m_hold == 0 && bus.en && m_pending != 0) begin
                for (int k = 0; k < int'(REQS); k++) begin
                    idx = (m_ptr + k) % int'(REQS);
                    if (clr == 0 && m_pending[idx]) begin
                        clr[idx] = 1'b1;
                        m_ptr = (idx + 1) % int'(REQS);
                        m_dir = DMSK[idx];
                    end
                end
                m_step = 1; m_grant = clr;
                m_hold = GAP + 1;
            end else if (m_hold > 0) begin
                m_hold--;
            end
            m_dropped = rise & m_pending & ~clr;
            m_pending = (m_pending & ~clr) | rise;
            m_busy = (m_hold != 0);
        end
    end

    // Step log and cycle counter, sampled just after the active edge.
    int         cyc = 0;
    int         drop0_cnt = 0;
    logic [3:0] g_log[$];
    logic       d_log[$];
    int         c_log[$];

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.step === 1'b1) begin
            g_log.push_back(bus.grant);
            d_log.push_back(bus.dir);
            c_log.push_back(cyc);
        end
        if (bus.dropped[0] === 1'b1) drop0_cnt++;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("step",    32'(bus.step),    32'(m_step));
            chk("dir",     32'(bus.dir),     32'(m_dir));
            chk("grant",   32'(bus.grant),   32'(m_grant));
            chk("pending", 32'(bus.pending), 32'(m_pending));
            chk("dropped", 32'(bus.dropped), 32'(m_dropped));
            chk("busy",    32'(bus.busy),    32'(m_busy));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    int base, press;
    bit seen;

    initial begin
        bus.en  = 1'b1;
        bus.req = 4'b0010;
        tick(3);
        chk("rst_step",    32'(bus.step),    0);
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_pending", 32'(bus.pending), 0);

        // Button held through reset release, then re-pressed.
        rst  = 1'b1;
        base = g_log.size();
        tick(20);
        chk("t1_no_step", 32'(g_log.size() - base), 0);
        chk("t1_pending", 32'(bus.pending), 0);
        bus.req = 4'b0000;
        tick(2);
        press = cyc;
        bus.req = 4'b0010;
        tick(4);
        chk("t1_one_step", 32'(g_log.size() - base), 1);
        if (g_log.size() > base) begin
            chk("t1_grant",   32'(g_log[base]), 32'h2);
            chk("t1_latency", 32'(c_log[base] - press), 2);
        end
        bus.req = 4'b0000;
        tick(10);

        // Four simultaneous rises served in round-robin order.
        do_reset();
        base = g_log.size();
        bus.req = 4'b1111;
        tick(25);
        chk("t2_count", 32'(g_log.size() - base), 4);
        if (g_log.size() >= base + 4) begin
            chk("t2_g0", 32'(g_log[base]),   32'h1);
            chk("t2_g1", 32'(g_log[base+1]), 32'h2);
            chk("t2_g2", 32'(g_log[base+2]), 32'h4);
            chk("t2_g3", 32'(g_log[base+3]), 32'h8);
            chk("t2_d2", 32'(d_log[base+2]), 1);
            chk("t2_d3", 32'(d_log[base+3]), 0);
            chk("t2_gap01", 32'(c_log[base+1] - c_log[base]),   GAP + 2);
            chk("t2_gap23", 32'(c_log[base+3] - c_log[base+2]), GAP + 2);
        end
        bus.req = 4'b0000;
        tick(2);
        base = g_log.size();
        bus.req = 4'b0011;
        tick(4);
        if (g_log.size() > base) chk("t2_ptr_wrap", 32'(g_log[base]), 32'h1);
        else chk("t2_ptr_wrap_step", 0, 1);
        bus.req = 4'b0000;
        tick(12);

        // Repeated edges while queued are dropped.
        do_reset();
        bus.en = 1'b0;
        drop0_cnt = 0;
        base = g_log.size();
        bus.req = 4'b0001; tick(1);
        bus.req = 4'b0000; tick(1);
        bus.req = 4'b0001; tick(1);
        bus.req = 4'b0000; tick(1);
        bus.req = 4'b0001; tick(1);
        bus.req = 4'b0000; tick(2);
        chk("t3_pending", 32'(bus.pending), 32'h1);
        chk("t3_drops",   32'(drop0_cnt), 2);
        bus.en = 1'b1;
        tick(15);
        chk("t3_one_step", 32'(g_log.size() - base), 1);

        // Continuous re-presses on 0 and 2 alternate fairly.
        do_reset();
        base = g_log.size();
        for (int i = 0; i < 15; i++) begin
            bus.req = 4'b0101; tick(1);
            bus.req = 4'b0000; tick(1);
        end
        tick(20);
        chk("t4_enough", 32'(g_log.size() - base >= 4), 1);
        if (g_log.size() >= base + 4) begin
            chk("t4_g0", 32'(g_log[base]),   32'h1);
            chk("t4_g1", 32'(g_log[base+1]), 32'h4);
            chk("t4_g2", 32'(g_log[base+2]), 32'h1);
            chk("t4_g3", 32'(g_log[base+3]), 32'h4);
        end

        // Enable held low queues requests; raising it drains them.
        do_reset();
        bus.en = 1'b0;
        base = g_log.size();
        bus.req = 4'b0011;
        tick(5);
        chk("t5_no_step", 32'(g_log.size() - base), 0);
        chk("t5_pending", 32'(bus.pending), 32'h3);
        bus.en = 1'b1;
        tick(15);
        chk("t5_count", 32'(g_log.size() - base), 2);
        if (g_log.size() >= base + 2) begin
            chk("t5_g0",  32'(g_log[base]),   32'h1);
            chk("t5_g1",  32'(g_log[base+1]), 32'h2);
            chk("t5_gap", 32'(c_log[base+1] - c_log[base]), GAP + 2);
        end
        bus.req = 4'b0000;
        tick(3);

        // Reset during WAIT discards the queue.
        do_reset();
        bus.req = 4'b0001;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1);
            if (bus.step === 1'b1) seen = 1;
        end
        chk("t6_step_seen", 32'(seen), 1);
        bus.req = 4'b1001;
        tick(1);
        chk("t6_pending_wait", 32'(bus.pending), 32'h8);
        chk("t6_busy_wait",    32'(bus.busy), 1);
        rst = 1'b0;
        tick(1);
        chk("t6_rst_pending", 32'(bus.pending), 0);
        chk("t6_rst_busy",    32'(bus.busy), 0);
        chk("t6_rst_step",    32'(bus.step), 0);
        chk("t6_rst_grant",   32'(bus.grant), 0);
        rst = 1'b1;
        base = g_log.size();
        tick(20);
        chk("t6_no_step", 32'(g_log.size() - base), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
